// File: rtl/compressor_tree_pipe.sv
// compressor_tree_pipe
//   Pipelined carry-save reduction of NUM_IN operands down to a sum/carry pair,
//   or to a single sum when the optional final adder is built. Operands are
//   padded with zero vectors up to the next power of two (NPAD). Each 4:2 level
//   is registered. Every stage has valid/ready flow control, so an empty stage
//   can fill while the output is stalled.
//
//   Build option: define COMPRESSOR_TREE_PIPE_FINAL_ADDER_EN to add one
//   registered carry-propagate stage. out_o[0] then carries the full sum and
//   out_o[1] is zero.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high; drops all data in flight
//   valid_i      operand set valid
//   ready_o      the block accepts the operand set this cycle
//   is_signed_i  1: operands are two's complement, 0: unsigned (per set)
//   in_i         NUM_IN operands of IN_SIZE bits
//   valid_o      result valid
//   ready_i      downstream accepts the result
//   out_o        [0] sum vector, [1] carry vector (already aligned to bit 0)
module compressor_tree_pipe #(
    parameter int NUM_IN   = 12,
    parameter int IN_SIZE  = 18,
    parameter int OUT_SIZE = 23
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                is_signed_i,
    input  logic [IN_SIZE-1:0]  in_i [NUM_IN],
    output logic                valid_o,
    input  logic                ready_i,
    output logic [OUT_SIZE-1:0] out_o [2]
);
    localparam int LOG2N  = $clog2(NUM_IN);
    localparam int NPAD   = 1 << LOG2N;
    localparam int LEVELS = LOG2N - 1;
    localparam int NNODE  = NPAD - 2;      // registered vectors over all levels
    localparam int NSRC   = 2 * NPAD - 4;  // vectors that feed some level
    localparam int XW     = OUT_SIZE - IN_SIZE;

    // First node index written by level k. Levels are packed back to back.
    function automatic int ob(input int k);
        return NPAD - (NPAD >> (k - 1));
    endfunction

    function automatic logic [OUT_SIZE-1:0] maj(input logic [OUT_SIZE-1:0] a,
                                                input logic [OUT_SIZE-1:0] b,
                                                input logic [OUT_SIZE-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // 4:2 compressor built from two full-adder rows. The result is {carry, sum}.
    // The carry is already shifted left by one.
    function automatic logic [2*OUT_SIZE-1:0] csa42(input logic [OUT_SIZE-1:0] a,
                                                    input logic [OUT_SIZE-1:0] b,
                                                    input logic [OUT_SIZE-1:0] c,
                                                    input logic [OUT_SIZE-1:0] d);
        logic [OUT_SIZE-1:0] s1, c1;
        s1 = a ^ b ^ c;
        c1 = maj(a, b, c) << 1;
        return {maj(s1, c1, d) << 1, s1 ^ c1 ^ d};
    endfunction

    logic [OUT_SIZE-1:0] src    [NSRC];
    logic [OUT_SIZE-1:0] node_d [NNODE];
    logic [OUT_SIZE-1:0] node_q [NNODE];
    logic [LEVELS:1]     vld_q;
    logic [LEVELS:0]     vld_w;
    logic [LEVELS:1]     adv_w;
    logic                adv_tail;

    assign vld_w   = {vld_q, valid_i};
    assign ready_o = adv_w[1];

    // Every vector is widened to the full output width on entry. The wrap-around
    // of the carry-save pair then matches mod 2^OUT_SIZE at every level, and
    // is_signed_i only has to be applied here.
    always_comb begin
        for (int i = 0; i < NSRC; i++) src[i] = '0;
        for (int i = 0; i < NUM_IN; i++)
            src[i] = {{XW{is_signed_i & in_i[i][IN_SIZE-1]}}, in_i[i]};
        for (int i = 0; i < NPAD - 4; i++)
            src[NPAD + i] = node_q[i];
    end

    // Level k reads its inputs from src at offset 2*ob(k).
    // It writes its outputs to node_d starting at ob(k).
    always_comb begin
        logic [2*OUT_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < NNODE; i++) node_d[i] = '0;
        for (int k = 1; k <= LEVELS; k++) begin
            for (int g = 0; g < (NPAD >> (k + 1)); g++) begin
                r = csa42(src[2*ob(k) + 4*g],     src[2*ob(k) + 4*g + 1],
                          src[2*ob(k) + 4*g + 2], src[2*ob(k) + 4*g + 3]);
                node_d[ob(k) + 2*g]     = r[OUT_SIZE-1:0];
                node_d[ob(k) + 2*g + 1] = r[2*OUT_SIZE-1:OUT_SIZE];
            end
        end
    end

    // A stage may advance when it is empty or when every later stage can advance.
    always_comb begin
        logic a;
        adv_w = '0;
        a     = adv_tail;
        for (int k = LEVELS; k >= 1; k--) begin
            a        = a | ~vld_q[k];
            adv_w[k] = a;
        end
    end

    // Stage valid bits: level 1 .. level LEVELS
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            for (int k = 1; k <= LEVELS; k++)
                if (adv_w[k]) vld_q[k] <= vld_w[k-1];
        end
    end

    // Stage data: loaded only when a valid vector moves in
    always_ff @(posedge clk_i) begin
        for (int k = 1; k <= LEVELS; k++)
            if (adv_w[k] && vld_w[k-1])
                for (int j = ob(k); j < ob(k + 1); j++) node_q[j] <= node_d[j];
    end

`ifdef COMPRESSOR_TREE_PIPE_FINAL_ADDER_EN
    logic [OUT_SIZE-1:0] fa_q;
    logic                fa_vld_q;

    assign adv_tail = ~fa_vld_q | ready_i;
    assign valid_o  = fa_vld_q;

    // Final carry-propagate stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         fa_vld_q <= 1'b0;
        else if (adv_tail) fa_vld_q <= vld_q[LEVELS];
    end

    always_ff @(posedge clk_i) begin
        if (adv_tail && vld_q[LEVELS]) fa_q <= node_q[NPAD-4] + node_q[NPAD-3];
    end

    always_comb begin
        out_o[0] = '0;
        out_o[1] = '0;
        if (fa_vld_q) out_o[0] = fa_q;
    end
`else
    assign adv_tail = ready_i;
    assign valid_o  = vld_q[LEVELS];

    // Gate the unreset data registers so that out_o reads zero while nothing is valid
    always_comb begin
        out_o[0] = '0;
        out_o[1] = '0;
        if (vld_q[LEVELS]) begin
            out_o[0] = node_q[NPAD-4];
            out_o[1] = node_q[NPAD-3];
        end
    end
`endif

endmodule

// File: tb/tb_compressor_tree_pipe.sv
`timescale 1ns/1ps
module tb_compressor_tree_pipe;
    localparam int NUM_IN   = 12;
    localparam int IN_SIZE  = 18;
    localparam int OUT_SIZE = 23;
`ifdef COMPRESSOR_TREE_PIPE_FINAL_ADDER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                clk = 1'b0;
    logic                rst, valid_i, ready_o, is_signed_i, valid_o, ready_i;
    logic [IN_SIZE-1:0]  in_i  [NUM_IN];
    logic [OUT_SIZE-1:0] out_o [2];
    logic [OUT_SIZE-1:0] ps;

    always #5 clk = ~clk;

    compressor_tree_pipe #(.NUM_IN(NUM_IN), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .is_signed_i(is_signed_i), .in_i(in_i), .valid_o(valid_o),
        .ready_i(ready_i), .out_o(out_o)
    );

    assign ps = out_o[0] + out_o[1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_SIZE-1:0] model(input logic s);
        longint acc = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s) acc += longint'($signed(in_i[i]));
            else   acc += longint'(in_i[i]);
        end
        return acc[OUT_SIZE-1:0];
    endfunction

    task automatic set_ops(input logic [IN_SIZE-1:0] fill, input int pos, input logic [IN_SIZE-1:0] pval);
        for (int i = 0; i < NUM_IN; i++) in_i[i] = (i == pos) ? pval : fill;
    endtask

    task automatic rand_set();
        for (int i = 0; i < NUM_IN; i++) in_i[i] = IN_SIZE'($urandom);
        is_signed_i = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard: record accepted sets, compare results as they are consumed
    logic [OUT_SIZE-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int rx_cnt = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_i && ready_o) exp_q.push_back(model(is_signed_i));
            if (valid_o && ready_i) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0h with no set outstanding", ps);
                end else begin
                    check("stream_result", ps, exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic                sgn;
        logic [IN_SIZE-1:0]  fill;
        int                  pos;
        logic [IN_SIZE-1:0]  pval;
        logic [OUT_SIZE-1:0] exp;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rx0, ready_low, acc, stall_bad, vcount;
        bit a, have_ref;
        logic [OUT_SIZE-1:0] ref0, ref1;

        tbl[0]  = '{1'b1, 18'h3FFFF, 0,  18'h3FFFF, 23'h7FFFF4};
        tbl[1]  = '{1'b0, 18'h3FFFF, 0,  18'h3FFFF, 23'h2FFFF4};
        tbl[2]  = '{1'b1, 18'h1FFFF, 0,  18'h1FFFF, 23'h17FFF4};
        tbl[3]  = '{1'b1, 18'h20000, 0,  18'h20000, 23'h680000};
        tbl[4]  = '{1'b0, 18'h20000, 0,  18'h20000, 23'h180000};
        tbl[5]  = '{1'b0, 18'h00000, 11, 18'h3FFFF, 23'h03FFFF};
        tbl[6]  = '{1'b1, 18'h00000, 11, 18'h3FFFF, 23'h7FFFFF};
        tbl[7]  = '{1'b1, 18'h00001, 5,  18'h20000, 23'h7E000B};
        tbl[8]  = '{1'b0, 18'h00000, 0,  18'h00000, 23'h000000};
        tbl[9]  = '{1'b0, 18'h00001, 0,  18'h00001, 23'h00000C};
        tbl[10] = '{1'b0, 18'h3FFFF, 3,  18'h00000, 23'h2BFFF5};
        tbl[11] = '{1'b1, 18'h3FFFF, 3,  18'h1FFFF, 23'h01FFF4};

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; is_signed_i = 1'b0;
        set_ops('0, 0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_out0", out_o[0], 0);
        check("rst_out1", out_o[1], 0);
        rst = 1'b0;
        #1 check("rst_ready_o", ready_o, 1);

        // Directed vectors, one at a time, with latency measured
        for (int r = 0; r < 12; r++) begin
            @(posedge clk); #1;
            is_signed_i = tbl[r].sgn;
            set_ops(tbl[r].fill, tbl[r].pos, tbl[r].pval);
            valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            lat = 1;
            while (!valid_o && lat < 12) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("latency_%0d", r), lat, LAT);
            check($sformatf("vector_%0d", r), ps, tbl[r].exp);
        end

        // Mode changes per set: unsigned followed by signed, same operands
        @(posedge clk); #1;
        set_ops(18'h3FFFF, 0, 18'h3FFFF);
        is_signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        is_signed_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (LAT - 2) begin @(posedge clk); #1; end
        check("mode_first_valid", valid_o, 1);
        check("mode_unsigned", ps, 23'h2FFFF4);
        @(posedge clk); #1;
        check("mode_second_valid", valid_o, 1);
        check("mode_signed", ps, 23'h7FFFF4);
        @(posedge clk); #1;
        check("mode_idle", valid_o, 0);

        // Back-to-back stream of 20 random sets with the output always ready
        mon_en = 1'b1;
        rx0 = rx_cnt;
        ready_low = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            rand_set();
            valid_i = 1'b1;
            #1 if (!ready_o) ready_low++;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        check("stream_count", rx_cnt - rx0, 20);
        check("stream_ready_low", ready_low, 0);
        check("stream_queue_empty", exp_q.size(), 0);

        // Output stalled for 10 cycles while sets keep arriving
        ready_i = 1'b0;
        acc = 0; stall_bad = 0; have_ref = 1'b0;
        ref0 = '0; ref1 = '0;
        rx0 = rx_cnt;
        rand_set();
        valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            a = ready_o;
            if (valid_o) begin
                if (!have_ref) begin
                    ref0 = out_o[0]; ref1 = out_o[1]; have_ref = 1'b1;
                end else if (out_o[0] !== ref0 || out_o[1] !== ref1) begin
                    stall_bad++;
                end
            end
            @(posedge clk); #1;
            if (a) begin
                acc++;
                rand_set();
            end
        end
        #1;
        check("stall_accepted", acc, LAT);
        check("stall_ready_o", ready_o, 0);
        check("stall_valid_o", have_ref, 1);
        check("stall_out_stable", stall_bad, 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("stall_drain_count", rx_cnt - rx0, LAT);
        check("stall_queue_empty", exp_q.size(), 0);

        // Reset with two sets in flight
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rand_set(); valid_i = 1'b1;
        @(posedge clk); #1;
        rand_set();
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (LAT - 2) begin @(posedge clk); #1; end
        check("pre_reset_valid", valid_o, 1);
        rst = 1'b1;
        #1;
        check("reset_valid_o", valid_o, 0);
        check("reset_out0", out_o[0], 0);
        check("reset_out1", out_o[1], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("post_reset_ready", ready_o, 1);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (valid_o) vcount++;
        end
        check("post_reset_no_stale", vcount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
